// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side signal bundle for the hazard/scoreboard unit.
// master = datapath/control side, slave = hazard unit.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned PERF_W     = 16
);
  logic [REG_ADDR_W-1:0] RA1D, RA2D, WA3D;
  logic                  RegWriteD, mc_op_d;
  logic [REG_ADDR_W-1:0] RA1E, RA2E, WA3E;
  logic                  MemToRegE, mc_issue_e;
  logic [REG_ADDR_W-1:0] WA3M, WA3W;
  logic                  RegWriteM, RegWriteW;
  logic                  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  StallF, StallD, FlushD, FlushE;
  logic                  mc_busy, mc_wb_valid;
  logic [REG_ADDR_W-1:0] mc_wb_addr;
  logic [PERF_W-1:0]     stall_count;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, mc_op_d, RA1E, RA2E, WA3E, MemToRegE, mc_issue_e,
           WA3M, WA3W, RegWriteM, RegWriteW, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, mc_busy, mc_wb_valid,
           mc_wb_addr, stall_count
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, mc_op_d, RA1E, RA2E, WA3E, MemToRegE, mc_issue_e,
           WA3M, WA3W, RegWriteM, RegWriteW, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, mc_busy, mc_wb_valid,
           mc_wb_addr, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// 5-stage hazard unit: M/W forwarding, load-use stall, single multi-cycle unit scoreboard,
// selectable branch-flush mode and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned BR_MODE    = 1,
  parameter int unsigned PERF_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave hz_if
);
  localparam int unsigned CntW = $clog2(MC_LAT);

  logic [NUM_REGS-1:0]   busy_q;
  logic                  mc_busy_q;
  logic [CntW-1:0]       mc_cnt_q;
  logic [REG_ADDR_W-1:0] mc_wb_addr_q;
  logic [PERF_W-1:0]     stall_count_q;

  logic mc_wb_valid;
  logic ldr_stall, sb_stall, struct_stall, hz, pend;
  logic stall_f, stall_d, flush_d, flush_e, mc_issue;

  assign mc_wb_valid = mc_busy_q && (mc_cnt_q == '0);

  // The regfile writes on the falling edge, so a register retiring this cycle is readable in D.
  function automatic logic sb_hit(input logic [REG_ADDR_W-1:0] a);
    logic in_range;
    in_range = 32'(a) < NUM_REGS;
    return in_range && busy_q[a] && !(mc_wb_valid && (a == mc_wb_addr_q));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] ra);
    if (hz_if.RegWriteM && (ra == hz_if.WA3M))      return 2'b10;
    else if (hz_if.RegWriteW && (ra == hz_if.WA3W)) return 2'b01;
    else                                            return 2'b00;
  endfunction

  always_comb begin
    ldr_stall    = hz_if.MemToRegE &&
                   ((hz_if.RA1D == hz_if.WA3E) || (hz_if.RA2D == hz_if.WA3E));
    sb_stall     = sb_hit(hz_if.RA1D) || sb_hit(hz_if.RA2D) ||
                   (hz_if.RegWriteD && sb_hit(hz_if.WA3D));
    struct_stall = hz_if.mc_op_d && (hz_if.mc_issue_e || (mc_busy_q && !mc_wb_valid));
    hz           = ldr_stall || sb_stall || struct_stall;
    pend         = (BR_MODE != 0) && (hz_if.PCSrcD || hz_if.PCSrcE || hz_if.PCSrcM);
    if (rst) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = hz || pend;
      stall_d = hz;
      flush_d = hz_if.BranchTakenE || pend || ((BR_MODE != 0) && hz_if.PCSrcW);
      flush_e = hz || hz_if.BranchTakenE;
    end
    mc_issue = hz_if.mc_issue_e && !flush_e && !rst;
  end

  assign hz_if.ForwardAE   = rst ? 2'b00 : fwd_sel(hz_if.RA1E);
  assign hz_if.ForwardBE   = rst ? 2'b00 : fwd_sel(hz_if.RA2E);
  assign hz_if.StallF      = stall_f;
  assign hz_if.StallD      = stall_d;
  assign hz_if.FlushD      = flush_d;
  assign hz_if.FlushE      = flush_e;
  assign hz_if.mc_busy     = mc_busy_q;
  assign hz_if.mc_wb_valid = mc_wb_valid;
  assign hz_if.mc_wb_addr  = mc_wb_addr_q;
  assign hz_if.stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      mc_busy_q     <= 1'b0;
      mc_cnt_q      <= '0;
      mc_wb_addr_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (mc_wb_valid) begin
        if (32'(mc_wb_addr_q) < NUM_REGS) busy_q[mc_wb_addr_q] <= 1'b0;
        mc_busy_q <= 1'b0;
      end
      // A same-edge issue follows the retire so it wins, even for the same register.
      if (mc_issue) begin
        if (32'(hz_if.WA3E) < NUM_REGS) busy_q[hz_if.WA3E] <= 1'b1;
        mc_busy_q    <= 1'b1;
        mc_cnt_q     <= CntW'(MC_LAT - 1);
        mc_wb_addr_q <= hz_if.WA3E;
      end else if (mc_busy_q && (mc_cnt_q != '0)) begin
        mc_cnt_q <= mc_cnt_q - CntW'(1);
      end
      if (stall_d && (stall_count_q != '1)) stall_count_q <= stall_count_q + PERF_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: one stimulus stream drives a BR_MODE=0 and a BR_MODE=1 instance;
// a cycle-indexed reference model predicts outputs, a monitor pops and compares.
module tb_hazard_scoreboard_unit;
  localparam int MC_LAT = 4;
  localparam int PERF_W = 4;
  localparam int SMAX   = (1 << PERF_W) - 1;

  typedef struct {
    bit       rst;
    bit [3:0] ra1d, ra2d, wa3d, ra1e, ra2e, wa3e, wa3m, wa3w;
    bit       regwrite_d, mc_op_d, memtoreg_e, mc_issue_e, regwrite_m, regwrite_w;
    bit       pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, br_taken_e;
  } stim_t;

  typedef struct {
    bit [1:0] fa, fb;
    bit [1:0] sf, fd;  // indexed by BR_MODE
    bit       sd, fe, mc_busy, wb_valid;
    bit [3:0] wb_addr, stall_count;
  } exp_t;

  logic  clk = 1'b0;
  stim_t cur;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: one op in flight, retiring at an absolute cycle index.
  bit inflight;
  int dest, wb_cyc, cyc, wb_addr_m, stall_m;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_ADDR_W(4), .PERF_W(PERF_W)) bus[2] ();

  logic [1:0] fa_o[2], fb_o[2];
  logic       sf_o[2], sd_o[2], fd_o[2], fe_o[2], mb_o[2], wv_o[2];
  logic [3:0] wa_o[2], sc_o[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].RA1D = cur.ra1d;  assign bus[g].RA2D = cur.ra2d;  assign bus[g].WA3D = cur.wa3d;
    assign bus[g].RA1E = cur.ra1e;  assign bus[g].RA2E = cur.ra2e;  assign bus[g].WA3E = cur.wa3e;
    assign bus[g].WA3M = cur.wa3m;  assign bus[g].WA3W = cur.wa3w;
    assign bus[g].RegWriteD = cur.regwrite_d;  assign bus[g].mc_op_d = cur.mc_op_d;
    assign bus[g].MemToRegE = cur.memtoreg_e;  assign bus[g].mc_issue_e = cur.mc_issue_e;
    assign bus[g].RegWriteM = cur.regwrite_m;  assign bus[g].RegWriteW = cur.regwrite_w;
    assign bus[g].PCSrcD = cur.pcsrc_d;  assign bus[g].PCSrcE = cur.pcsrc_e;
    assign bus[g].PCSrcM = cur.pcsrc_m;  assign bus[g].PCSrcW = cur.pcsrc_w;
    assign bus[g].BranchTakenE = cur.br_taken_e;
    assign fa_o[g] = bus[g].ForwardAE;  assign fb_o[g] = bus[g].ForwardBE;
    assign sf_o[g] = bus[g].StallF;     assign sd_o[g] = bus[g].StallD;
    assign fd_o[g] = bus[g].FlushD;     assign fe_o[g] = bus[g].FlushE;
    assign mb_o[g] = bus[g].mc_busy;    assign wv_o[g] = bus[g].mc_wb_valid;
    assign wa_o[g] = bus[g].mc_wb_addr; assign sc_o[g] = bus[g].stall_count;

    hazard_scoreboard_unit #(
      .REG_ADDR_W(4), .NUM_REGS(16), .MC_LAT(MC_LAT), .BR_MODE(g), .PERF_W(PERF_W)
    ) u_dut (
      .clk   (clk),
      .rst   (cur.rst),
      .hz_if (bus[g])
    );
  end

  function automatic bit retiring();
    return inflight && (cyc == wb_cyc);
  endfunction

  function automatic bit reg_busy(input bit [3:0] r);
    return inflight && (int'(r) == dest) && !retiring();
  endfunction

  function automatic bit [1:0] fwd(input bit [3:0] ra, input stim_t s);
    if (s.regwrite_m && ra == s.wa3m) return 2'b10;
    if (s.regwrite_w && ra == s.wa3w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit   ldr, sb, st, hz, pend;
    ldr  = s.memtoreg_e && (s.ra1d == s.wa3e || s.ra2d == s.wa3e);
    sb   = reg_busy(s.ra1d) || reg_busy(s.ra2d) || (s.regwrite_d && reg_busy(s.wa3d));
    st   = s.mc_op_d && (s.mc_issue_e || (inflight && !retiring()));
    hz   = ldr || sb || st;
    pend = s.pcsrc_d || s.pcsrc_e || s.pcsrc_m;
    if (s.rst) begin
      e.fa = 2'b00; e.fb = 2'b00; e.sf = 2'b00; e.sd = 1'b0; e.fd = 2'b11; e.fe = 1'b1;
    end else begin
      e.fa    = fwd(s.ra1e, s);
      e.fb    = fwd(s.ra2e, s);
      e.sd    = hz;
      e.fe    = hz || s.br_taken_e;
      e.sf[0] = hz;
      e.sf[1] = hz || pend;
      e.fd[0] = s.br_taken_e;
      e.fd[1] = s.br_taken_e || pend || s.pcsrc_w;
    end
    e.mc_busy     = inflight;
    e.wb_valid    = retiring();
    e.wb_addr     = 4'(wb_addr_m);
    e.stall_count = 4'(stall_m);
    return e;
  endfunction

  task automatic advance_model(input stim_t s, input exp_t e);
    if (s.rst) begin
      inflight  = 1'b0;
      wb_addr_m = 0;
      stall_m   = 0;
    end else begin
      if (e.sd && stall_m < SMAX) stall_m++;
      if (e.wb_valid) inflight = 1'b0;
      if (s.mc_issue_e && !e.fe) begin
        inflight  = 1'b1;
        dest      = int'(s.wa3e);
        wb_addr_m = int'(s.wa3e);
        wb_cyc    = cyc + MC_LAT;
      end
    end
    cyc++;
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic step(input stim_t s);
    exp_t e;
    cur = s;
    e = predict(s);
    q.push_back(e);
    @(posedge clk);
    advance_model(s, e);
    #1;
  endtask

  task automatic cmp(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, g, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int g = 0; g < 2; g++) begin
        cmp("ForwardAE", g, 32'(fa_o[g]), 32'(e.fa));
        cmp("ForwardBE", g, 32'(fb_o[g]), 32'(e.fb));
        cmp("StallF", g, 32'(sf_o[g]), 32'(e.sf[g]));
        cmp("StallD", g, 32'(sd_o[g]), 32'(e.sd));
        cmp("FlushD", g, 32'(fd_o[g]), 32'(e.fd[g]));
        cmp("FlushE", g, 32'(fe_o[g]), 32'(e.fe));
        cmp("mc_busy", g, 32'(mb_o[g]), 32'(e.mc_busy));
        cmp("mc_wb_valid", g, 32'(wv_o[g]), 32'(e.wb_valid));
        cmp("mc_wb_addr", g, 32'(wa_o[g]), 32'(e.wb_addr));
        cmp("stall_count", g, 32'(sc_o[g]), 32'(e.stall_count));
      end
    end
  end

  initial begin
    stim_t s, idle;
    idle = '{default: '0};
    idle.ra1d = 4'd9; idle.ra2d = 4'd10; idle.wa3d = 4'd11;
    idle.ra1e = 4'd12; idle.ra2e = 4'd13; idle.wa3e = 4'd14; idle.wa3m = 4'd15; idle.wa3w = 4'd1;
    cur = idle;
    cur.rst = 1'b1;
    inflight = 1'b0; dest = 0; wb_cyc = 0; cyc = 0; wb_addr_m = 0; stall_m = 0;
    @(posedge clk);
    #1;
    s = idle; s.rst = 1'b1; step(s);
    step(idle);

    // Forwarding priority
    s = idle; s.regwrite_m = 1; s.wa3m = 3; s.regwrite_w = 1; s.wa3w = 3; s.ra1e = 3; s.ra2e = 5;
    step(s);
    s.regwrite_m = 0; step(s);

    // Load-use
    s = idle; s.memtoreg_e = 1; s.wa3e = 2; s.ra2d = 2; step(s);
    step(idle);

    // Multi-cycle issue to R7 with a dependent reader in D
    s = idle; s.mc_issue_e = 1; s.wa3e = 7; step(s);
    s = idle; s.ra1d = 7;
    for (int i = 0; i < MC_LAT; i++) step(s);
    step(idle);

    // WAW then structural stall up to the writeback cycle
    s = idle; s.mc_issue_e = 1; s.wa3e = 7; step(s);
    s = idle; s.regwrite_d = 1; s.wa3d = 7; step(s);
    s = idle; s.mc_op_d = 1;
    for (int i = 0; i < MC_LAT; i++) step(s);
    step(idle);

    // Branch modes
    s = idle; s.pcsrc_d = 1; step(s);
    s = idle; s.pcsrc_w = 1; step(s);
    s = idle; s.br_taken_e = 1; step(s);
    s = idle; s.br_taken_e = 1; s.mc_issue_e = 1; s.wa3e = 4; step(s);

    // Reset while an op is in flight
    s = idle; s.mc_issue_e = 1; s.wa3e = 5; step(s);
    step(idle); step(idle);
    s = idle; s.rst = 1; step(s);
    for (int i = 0; i < MC_LAT + 2; i++) step(idle);

    // Saturating stall counter
    s = idle; s.memtoreg_e = 1; s.wa3e = 6; s.ra1d = 6;
    for (int i = 0; i < SMAX + 5; i++) step(s);
    s = idle; s.rst = 1; step(s);

    // Randomised traffic; issue only when the unit is free or retiring
    for (int n = 0; n < 3000; n++) begin
      s.rst        = ($urandom_range(0, 199) == 0);
      s.ra1d       = 4'($urandom_range(0, 7)); s.ra2d = 4'($urandom_range(0, 7));
      s.wa3d       = 4'($urandom_range(0, 7)); s.ra1e = 4'($urandom_range(0, 7));
      s.ra2e       = 4'($urandom_range(0, 7)); s.wa3e = 4'($urandom_range(0, 7));
      s.wa3m       = 4'($urandom_range(0, 7)); s.wa3w = 4'($urandom_range(0, 7));
      s.regwrite_d = 1'($urandom_range(0, 1));
      s.mc_op_d    = ($urandom_range(0, 3) == 0);
      s.memtoreg_e = ($urandom_range(0, 3) == 0);
      s.mc_issue_e = (!inflight || retiring()) && ($urandom_range(0, 2) == 0);
      s.regwrite_m = 1'($urandom_range(0, 1));
      s.regwrite_w = 1'($urandom_range(0, 1));
      s.pcsrc_d    = ($urandom_range(0, 5) == 0);
      s.pcsrc_e    = ($urandom_range(0, 5) == 0);
      s.pcsrc_m    = ($urandom_range(0, 5) == 0);
      s.pcsrc_w    = ($urandom_range(0, 5) == 0);
      s.br_taken_e = ($urandom_range(0, 7) == 0);
      step(s);
    end

    cur = idle;
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
